// File: rtl/ascon_sbox_layer.sv
// rtl/ascon_sbox_layer.sv - iterative ASCON S-box layer over the 320-bit state
//
// Purpose:
//    Applies the 5-bit ASCON S-box, or its inverse, to all 64 columns of the
//    permutation state. Each clock handles COLS_PER_CYCLE columns, so a state
//    is finished after N = 64/COLS_PER_CYCLE cycles.
//
// Ports:
//    clk        rising-edge clock
//    rst        synchronous active-high reset
//    in_valid   in_state / in_inv valid
//    in_ready   block can accept a state (IDLE only)
//    in_inv     0 = forward S-box, 1 = inverse S-box, latched on accept
//    in_state   x0=[63:0] x1=[127:64] x2=[191:128] x3=[255:192] x4=[319:256]
//    out_valid  out_state holds the finished result (DONE)
//    out_ready  downstream takes out_state
//    out_state  substituted state, same packing as in_state
//    busy       high in RUN or DONE

module ascon_sbox_layer #(
   parameter int COLS_PER_CYCLE = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_inv,
   input  logic [319:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [319:0] out_state,
   output logic         busy
);

   localparam int C  = COLS_PER_CYCLE;
   localparam int N  = 64 / C;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if (C != 1 && C != 2 && C != 4 && C != 8 && C != 16 && C != 32 && C != 64) begin : g_bad_param
      $error("ascon_sbox_layer: COLS_PER_CYCLE must be 1,2,4,8,16,32 or 64");
   end

   localparam logic [4:0] SBOX_FWD [32] = '{
      5'd4,  5'd11, 5'd31, 5'd20, 5'd26, 5'd21, 5'd9,  5'd2,
      5'd27, 5'd5,  5'd8,  5'd18, 5'd29, 5'd3,  5'd6,  5'd28,
      5'd30, 5'd19, 5'd7,  5'd14, 5'd0,  5'd13, 5'd17, 5'd24,
      5'd16, 5'd12, 5'd1,  5'd25, 5'd22, 5'd10, 5'd15, 5'd23
   };

   localparam logic [4:0] SBOX_INV [32] = '{
      5'd20, 5'd26, 5'd7,  5'd13, 5'd0,  5'd9,  5'd14, 5'd18,
      5'd10, 5'd6,  5'd29, 5'd1,  5'd25, 5'd21, 5'd19, 5'd30,
      5'd24, 5'd22, 5'd11, 5'd17, 5'd3,  5'd5,  5'd28, 5'd31,
      5'd23, 5'd27, 5'd4,  5'd8,  5'd15, 5'd12, 5'd16, 5'd2
   };

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [319:0]    r_reg;
   logic            r_mode;
   logic [CW-1:0]   r_cnt;

   logic            w_last;
   logic [8:0]      w_base;
   logic [C-1:0]    w_x0_sl, w_x1_sl, w_x2_sl, w_x3_sl, w_x4_sl;
   logic [C-1:0]    w_x0_new, w_x1_new, w_x2_new, w_x3_new, w_x4_new;
   logic [319:0]    w_reg_run;

   // First column of the slice handled this cycle
   assign w_base = 9'(r_cnt) * 9'(C);
   assign w_last = (r_cnt == CW'(N - 1));

   assign w_x0_sl = r_reg[w_base +: C];
   assign w_x1_sl = r_reg[9'd64  + w_base +: C];
   assign w_x2_sl = r_reg[9'd128 + w_base +: C];
   assign w_x3_sl = r_reg[9'd192 + w_base +: C];
   assign w_x4_sl = r_reg[9'd256 + w_base +: C];

   // One forward and one inverse lookup per column of the slice; x0 is the index MSB
   for (genvar k = 0; k < C; k++) begin : g_col
      logic [4:0] w_idx;
      logic [4:0] w_fwd;
      logic [4:0] w_inv;
      logic [4:0] w_sub;

      assign w_idx = {w_x0_sl[k], w_x1_sl[k], w_x2_sl[k], w_x3_sl[k], w_x4_sl[k]};
      assign w_fwd = SBOX_FWD[w_idx];
      assign w_inv = SBOX_INV[w_idx];
      assign w_sub = r_mode ? w_inv : w_fwd;

      assign w_x0_new[k] = w_sub[4];
      assign w_x1_new[k] = w_sub[3];
      assign w_x2_new[k] = w_sub[2];
      assign w_x3_new[k] = w_sub[1];
      assign w_x4_new[k] = w_sub[0];
   end

   // Columns outside the active slice pass through unchanged
   always_comb begin
      w_reg_run = r_reg;
      w_reg_run[w_base +: C]          = w_x0_new;
      w_reg_run[9'd64  + w_base +: C] = w_x1_new;
      w_reg_run[9'd128 + w_base +: C] = w_x2_new;
      w_reg_run[9'd192 + w_base +: C] = w_x3_new;
      w_reg_run[9'd256 + w_base +: C] = w_x4_new;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_reg   <= '0;
         r_mode  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_reg  <= in_state;
                  r_mode <= in_inv;
                  r_cnt  <= '0;
               end
            end
            S_RUN: begin
               r_reg <= w_reg_run;
               // Explicit wrap keeps the N=1 case (1-bit counter) at zero
               r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign out_state = r_reg;
   assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_ascon_sbox_layer.sv
// tb/tb_ascon_sbox_layer.sv - scoreboard bench for ascon_sbox_layer at 8, 1 and 64 columns per cycle

module tb_ascon_sbox_layer;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid  [3];
   logic         in_ready  [3];
   logic         in_inv    [3];
   logic [319:0] in_state  [3];
   logic         out_valid [3];
   logic         out_ready [3];
   logic [319:0] out_state [3];
   logic         busy      [3];

   logic [319:0] exp_q [3][$];
   int           n_checks = 0;
   int           n_fail   = 0;
   int           cyc      = 0;

   int SB [32] = '{4, 11, 31, 20, 26, 21, 9, 2, 27, 5, 8, 18, 29, 3, 6, 28,
                   30, 19, 7, 14, 0, 13, 17, 24, 16, 12, 1, 25, 22, 10, 15, 23};

   localparam logic [63:0] Z = 64'h0;
   localparam logic [63:0] O = 64'hFFFF_FFFF_FFFF_FFFF;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk320(input string nm, input logic [319:0] act, input logic [319:0] ex);
      n_checks++;
      if (act !== ex) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, ex);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int ex);
      n_checks++;
      if (act != ex) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, ex);
      end
   endtask

   task automatic timeout(input string nm);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out", nm);
   endtask

   function automatic logic [319:0] pack(input logic [63:0] x0, x1, x2, x3, x4);
      return {x4, x3, x2, x1, x0};
   endfunction

   function automatic logic [319:0] model_fwd(input logic [319:0] s);
      logic [319:0] r;
      logic [4:0]   ix;
      logic [4:0]   v;
      r = s;
      for (int j = 0; j < 64; j++) begin
         ix = {s[j], s[64+j], s[128+j], s[192+j], s[256+j]};
         v  = 5'(SB[ix]);
         r[j]     = v[4];
         r[64+j]  = v[3];
         r[128+j] = v[2];
         r[192+j] = v[1];
         r[256+j] = v[0];
      end
      return r;
   endfunction

   function automatic logic [319:0] rand320();
      logic [319:0] r;
      for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int CPC = (g == 0) ? 8 : (g == 1) ? 1 : 64;
      localparam int NL  = 64 / CPC;

      ascon_sbox_layer #(.COLS_PER_CYCLE(CPC)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_inv    (in_inv[g]),
         .in_state  (in_state[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .out_state (out_state[g]),
         .busy      (busy[g])
      );

      int   t_acc   = 0;
      logic prev_ov = 1'b0;

      always @(negedge clk) begin
         if (rst) begin
            prev_ov = 1'b0;
         end else begin
            if (in_valid[g] && in_ready[g]) t_acc = cyc + 1;
            if (out_valid[g] && !prev_ov)
               chk_int($sformatf("latency_c%0d", CPC), cyc - t_acc, NL);
            if (out_valid[g] && out_ready[g]) begin
               if (exp_q[g].size() == 0) begin
                  timeout($sformatf("unexpected_output_c%0d", CPC));
               end else begin
                  chk320($sformatf("out_state_c%0d", CPC), out_state[g], exp_q[g].pop_front());
               end
            end
            prev_ov = out_valid[g];
         end
      end
   end

   task automatic send(input int idx, input logic [319:0] st, input logic inv, input logic [319:0] ex);
      int n;
      n = 0;
      exp_q[idx].push_back(ex);
      in_state[idx] = st;
      in_inv[idx]   = inv;
      in_valid[idx] = 1'b1;
      @(negedge clk);
      while (!in_ready[idx] && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready[idx]) timeout("send_accept");
      @(posedge clk);
      #1;
      in_valid[idx] = 1'b0;
      in_inv[idx]   = ~inv;
      in_state[idx] = rand320();
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      if (n >= 2000) timeout("drain");
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [319:0] t1_exp, t2_exp, t3_in, t3_exp, inv0_exp, st, f;
      int           n;

      t1_exp   = pack(Z, Z, O, Z, Z);
      inv0_exp = pack(O, Z, O, Z, Z);
      t2_exp   = pack(O, Z, O, O, O);
      t3_in    = pack(Z, Z, Z, Z, 64'h1);
      t3_exp   = pack(Z, 64'h1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 64'h1);

      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid[i]  = 1'b0;
         in_inv[i]    = 1'b0;
         in_state[i]  = '0;
         out_ready[i] = 1'b1;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk_int("reset_in_ready", int'(in_ready[i]), 1);
         chk_int("reset_out_valid", int'(out_valid[i]), 0);
         chk_int("reset_busy", int'(busy[i]), 0);
         chk320("reset_out_state", out_state[i], '0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Directed vectors on the 8-column instance
      send(0, '0, 1'b0, t1_exp);
      send(0, '0, 1'b1, inv0_exp);
      send(0, {5{O}}, 1'b0, t2_exp);
      send(0, t2_exp, 1'b1, {5{O}});
      send(0, t3_in, 1'b0, t3_exp);
      drain();

      // Random round trips on all three widths
      for (int g = 0; g < 3; g++) begin
         for (int r = 0; r < 3; r++) begin
            st = rand320();
            f  = model_fwd(st);
            send(g, st, 1'b0, f);
            send(g, f, 1'b1, st);
         end
      end
      drain();

      // Back-pressure in DONE
      out_ready[0] = 1'b0;
      send(0, t3_in, 1'b0, t3_exp);
      n = 0;
      @(negedge clk);
      while (!out_valid[0] && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid[0]) timeout("wait_done");
      @(posedge clk);
      #1;
      in_valid[0] = 1'b1;
      in_state[0] = rand320();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk320("hold_out_state", out_state[0], t3_exp);
         chk_int("hold_out_valid", int'(out_valid[0]), 1);
         chk_int("hold_in_ready", int'(in_ready[0]), 0);
         chk_int("hold_busy", int'(busy[0]), 1);
         @(posedge clk);
         #1;
      end
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk_int("release_in_ready", int'(in_ready[0]), 1);
      chk_int("release_out_valid", int'(out_valid[0]), 0);
      chk_int("release_busy", int'(busy[0]), 0);
      drain();

      // Reset in the middle of RUN, with cnt at 3
      send(0, t3_in, 1'b0, t3_exp);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q[0].delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk_int("midrun_rst_in_ready", int'(in_ready[0]), 1);
      chk_int("midrun_rst_out_valid", int'(out_valid[0]), 0);
      chk_int("midrun_rst_busy", int'(busy[0]), 0);
      chk320("midrun_rst_out_state", out_state[0], '0);
      @(posedge clk);
      #1;
      send(0, '0, 1'b0, t1_exp);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
